apb_regfile_slave: RTL and testbench
====================================

// Module: apb_regfile_slave
// PURPOSE
//  APB slave sitting directly downstream of the APB bus/bridge: consumes PSELx/PENABLE/PWRITE/PADDR/PWDATA,
//  answers with PREADY/PRDATA/PSLVERR. Holds NUM_REGS x 32-bit registers (addr 0 = read-only ID),
//  inserts WAIT_CYCLES programmable wait states, flags bad accesses, counts errors.
// PARAMETERS
//  NUM_REGS     16            implemented registers (2..32); addr >= NUM_REGS is unmapped
//  WAIT_CYCLES  0             extra access-phase cycles before PREADY (0..15)
//  ID_VALUE     32'hA5B0_0001 constant returned by register 0
// PORTS
//  PCLK       in   1   clock; all logic on rising edge
//  PRESET     in   1   reset, synchronous, active-high
//  PSEL       in   1   slave select (PSEL1 or PSEL2 from the bus)
//  PENABLE    in   1   access-phase enable
//  PWRITE     in   1   1 = write, 0 = read
//  PADDR      in   5   word address
//  PWDATA     in   32  write data
//  PREADY     out  1   transfer complete (registered)
//  PRDATA     out  32  read data, valid only while PREADY=1 (registered)
//  PSLVERR    out  1   error, valid only while PREADY=1 (registered)
//  err_count  out  8   saturating count of PSLVERR responses
// BEHAVIOUR
//  - Reset (sync, PRESET=1 at edge): state IDLE, PREADY=0, PRDATA=0, PSLVERR=0, err_count=0, regs 1..N-1 = 0;
//    any in-flight transfer dropped, no write committed. Reset dominates all other events.
//  - FSM IDLE -> WAIT -> DONE -> IDLE; PREADY=1 only in DONE, exactly one cycle per transfer.
//  - IDLE: PSEL & !PENABLE (setup) -> latch addr/write/wdata; cnt <= WAIT_CYCLES;
//    next = (WAIT_CYCLES==0) ? DONE : WAIT. So with 0 waits PREADY=1 in first access cycle.
//  - IDLE: PSEL & PENABLE with no prior setup = protocol error -> DONE with PSLVERR=1, no write.
//  - WAIT: PSEL & PENABLE -> cnt--; cnt==1 -> DONE. PSEL=0 (abort) -> IDLE, nothing committed, no response.
//    Addr/data changes during WAIT ignored (latched copies used).
//  - DONE: PREADY=1. Write committed at the edge ending DONE (reg[addr] <= wdata) iff no error.
//    Read: PRDATA = reg[addr] (addr 0 -> ID_VALUE); error reads return PRDATA=0. Next = IDLE.
//  - Errors (PSLVERR=1 in DONE): latched addr >= NUM_REGS; write to addr 0; protocol error.
//  - err_count += 1 at edge ending each DONE with PSLVERR=1; saturates at 8'hFF.
//  - Back-to-back: master re-enters setup the cycle after DONE; IDLE accepts it with no bubble.
//  - Total latency setup->PREADY = WAIT_CYCLES+1 cycles after setup edge.
//  - Outside DONE: PREADY=0, PSLVERR=0, PRDATA=0.
// STRUCTURE
//  - apb_pkg: state enum {IDLE,WAIT,DONE}, APB_ADDR_W=5, APB_DATA_W=32, ERR_CNT_W=8.
//  - Sub-module apb_reg_array: NUM_REGS x 32 storage, 1 write port (we/addr/wdata), 1 comb read port,
//    addr 0 hardwired to ID_VALUE; parent owns FSM, wait counter, error decode, response regs.
// TESTING
//  - Reset mid-WAIT (WAIT_CYCLES=3, PRESET at 2nd access cycle) -> PREADY stays 0, reg unchanged, err_count=0.
//  - WAIT_CYCLES=0: write 32'hDEADBEEF to addr 3, then read addr 3 -> PREADY in 1st access cycle, PRDATA=DEADBEEF.
//  - WAIT_CYCLES=2: read addr 0 -> PREADY exactly 3rd access cycle, PRDATA=32'hA5B0_0001, PSLVERR=0.
//  - Write addr 0 and read addr 20 (NUM_REGS=16) -> PSLVERR=1 each, PRDATA=0, reg0 unchanged, err_count=2.
//  - PSEL=1,PENABLE=1 from IDLE without setup -> PSLVERR=1 next cycle; abort (PSEL=0) in WAIT -> no response.
//  - 260 error transfers -> err_count saturates at 8'hFF; back-to-back writes addr 1..15 all commit, no bubbles.

Source files
------------

// File: rtl/apb_regfile_slave_pkg.sv
// apb_regfile_slave_pkg: shared widths and FSM state type for the APB register-file slave
package apb_regfile_slave_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 32;
    localparam int ERR_CNT_W  = 8;
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB completer-side bus bundle with master/slave views
interface apb_regfile_slave_if import apb_regfile_slave_pkg::*; ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic                  pready;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_regfile_slave_reg_array.sv
// apb_reg_array: register storage with one write port and one combinational read port; address 0 reads ID_VALUE
module apb_reg_array import apb_regfile_slave_pkg::*; #(
    parameter int                    NUM_REGS = 16,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [APB_ADDR_W-1:0] i_waddr,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [APB_ADDR_W-1:0] i_raddr,
    output logic [APB_DATA_W-1:0] o_rdata
);
    localparam int AW = $clog2(NUM_REGS);
    logic [APB_DATA_W-1:0] r_regs [NUM_REGS];
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    assign w_wr_ok = i_we && i_waddr != '0 && int'(i_waddr) < NUM_REGS;
    assign w_rd_ok = int'(i_raddr) < NUM_REGS;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        else if (w_wr_ok)
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
    assign o_rdata = (i_raddr == '0) ? ID_VALUE : w_rd_ok ? r_regs[i_raddr[AW-1:0]] : '0;
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer with a register file, programmable wait states and a saturating error counter
module apb_regfile_slave import apb_regfile_slave_pkg::*; #(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    apb_regfile_slave_if.slave   s_apb,
    output logic [ERR_CNT_W-1:0] o_err_count
);
    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [APB_ADDR_W-1:0] r_addr;
    logic [APB_DATA_W-1:0] r_wdata;
    logic                  r_write;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_bad;
    logic                  w_we;
    logic [APB_DATA_W-1:0] w_rdata;
    assign w_setup  = s_apb.psel && !s_apb.penable;
    assign w_access = s_apb.psel && s_apb.penable;
    assign w_bad    = int'(s_apb.paddr) >= NUM_REGS || (s_apb.pwrite && s_apb.paddr == '0);
    assign w_we     = r_state == DONE && r_write && !r_err;
    assign o_err_count = r_err_count;
    apb_reg_array #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) u_regs (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // An access phase seen straight from IDLE is a protocol error and completes on the next cycle
    always_comb begin
        w_next = r_state == IDLE ? (w_setup ? (WAIT_CYCLES == 0 ? DONE : WAIT) : w_access ? DONE : IDLE)
               : r_state == WAIT ? (!s_apb.psel ? IDLE : (s_apb.penable && r_cnt == 4'd1) ? DONE : WAIT)
               : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (r_state == IDLE && s_apb.psel) begin
                r_addr  <= s_apb.paddr;
                r_wdata <= s_apb.pwdata;
                r_write <= s_apb.pwrite && !s_apb.penable;
                r_err   <= s_apb.penable || w_bad;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == WAIT && w_access) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == DONE && r_err && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        end
    end
    always_comb begin
        s_apb.pready  = r_state == DONE;
        s_apb.pslverr = r_state == DONE && r_err;
        s_apb.prdata  = (r_state == DONE && !r_err && !r_write) ? w_rdata : '0;
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: three slaves (0, 2 and 3 wait states) checked every cycle against a transaction-level model
module tb_apb_regfile_slave;
    localparam logic [31:0] ID = 32'hA5B0_0001;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst [3];
    logic        psel [3];
    logic        pen [3];
    logic        pwr [3];
    logic [4:0]  paddr [3];
    logic [31:0] pwdata [3];
    logic        pready [3];
    logic        pslverr [3];
    logic [31:0] prdata [3];
    logic [7:0]  errc [3];
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_regfile_slave_if bus ();
        assign bus.psel    = psel[g];
        assign bus.penable = pen[g];
        assign bus.pwrite  = pwr[g];
        assign bus.paddr   = paddr[g];
        assign bus.pwdata  = pwdata[g];
        assign pready[g]   = bus.pready;
        assign pslverr[g]  = bus.pslverr;
        assign prdata[g]   = bus.prdata;
        apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 2 : 3), .ID_VALUE(ID)) dut (
            .i_clk       (clk),
            .i_rst       (rst[g]),
            .s_apb       (bus.slave),
            .o_err_count (errc[g])
        );
    end
    logic [31:0] mem [3][32];
    int          errm [3];
    logic        e_rdy [3];
    logic        e_err [3];
    logic [31:0] e_dat [3];
    bit          run;
    int          total;
    int          bad;
    bit          p_v, p_rst, p_we, p_err;
    int          p_k;
    logic [4:0]  p_a;
    logic [31:0] p_d;

    function automatic int wcf(int k);
        return k == 0 ? 0 : k == 1 ? 2 : 3;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                chk("pready", k, 32'(pready[k]), 32'(e_rdy[k]));
                chk("pslverr", k, 32'(pslverr[k]), 32'(e_err[k]));
                chk("prdata", k, prdata[k], e_dat[k]);
                chk("err_count", k, 32'(errc[k]), 32'(errm[k]));
            end
        end
    end

    // One bus cycle on instance k; effects of the previous cycle's closing edge are folded into the model first
    task automatic step(int k, bit r, bit s, bit en, bit wr, logic [4:0] a, logic [31:0] d, bit xr, bit xe, logic [31:0] xd);
        @(posedge clk);
        #1;
        if (p_v) begin
            if (p_rst) begin
                for (int i = 0; i < 32; i++) mem[p_k][i] = '0;
                errm[p_k] = 0;
            end else begin
                if (p_we) mem[p_k][p_a] = p_d;
                if (p_err && errm[p_k] < 255) errm[p_k]++;
            end
            p_v = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            rst[j] = 1'b0; psel[j] = 1'b0; pen[j] = 1'b0; pwr[j] = 1'($urandom);
            paddr[j] = 5'($urandom); pwdata[j] = $urandom;
            e_rdy[j] = 1'b0; e_err[j] = 1'b0; e_dat[j] = '0;
        end
        rst[k] = r; psel[k] = s; pen[k] = en; pwr[k] = wr; paddr[k] = a; pwdata[k] = d;
        e_rdy[k] = xr; e_err[k] = xe; e_dat[k] = xd;
        if (r) begin
            p_v = 1'b1; p_k = k; p_rst = 1'b1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic xfer(int k, bit wr, logic [4:0] a, logic [31:0] d, output logic [31:0] rd, output logic rr, output logic re);
        int w;
        bit er;
        logic [31:0] xd;
        w = wcf(k);
        er = (a >= 5'd16) || (wr && a == 5'd0);
        step(k, 0, 1, 0, wr, a, d, 0, 0, 32'd0);
        xd = (er || wr) ? 32'd0 : (a == 5'd0 ? ID : mem[k][a]);
        for (int j = 1; j <= w + 1; j++)
            step(k, 0, 1, 1, wr, 5'($urandom), $urandom, j == w + 1, (j == w + 1) && er, j == w + 1 ? xd : 32'd0);
        p_v = 1'b1; p_k = k; p_rst = 1'b0; p_we = wr && !er; p_a = a; p_d = d; p_err = er;
        @(negedge clk);
        rd = prdata[k]; rr = pready[k]; re = pslverr[k];
    endtask

    task automatic proto(int k);
        step(k, 0, 1, 1, 1'($urandom), 5'($urandom), $urandom, 0, 0, 32'd0);
        step(k, 0, 0, 0, 0, 5'd0, 32'd0, 1, 1, 32'd0);
        p_v = 1'b1; p_k = k; p_rst = 1'b0; p_we = 1'b0; p_err = 1'b1;
    endtask

    task automatic abort(int k, int n);
        step(k, 0, 1, 0, 1'($urandom), 5'($urandom_range(1, 15)), $urandom, 0, 0, 32'd0);
        for (int j = 0; j < n; j++) step(k, 0, 1, 1, 1'($urandom), 5'($urandom), $urandom, 0, 0, 32'd0);
        step(k, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        rr, re;
        logic [31:0] wd [16];
        total = 0; bad = 0; run = 1'b0; p_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
            e_rdy[k] = 1'b0; e_err[k] = 1'b0; e_dat[k] = '0; errm[k] = 0;
            for (int i = 0; i < 32; i++) mem[k][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        run = 1'b1;
        idle(2);
        // zero wait states: write then read back with no bubble
        xfer(0, 1, 5'd3, 32'hDEADBEEF, rd, rr, re);
        chk("w0_wr_ready", 0, 32'(rr), 32'd1);
        xfer(0, 0, 5'd3, 32'd0, rd, rr, re);
        chk("w0_rd_data", 0, rd, 32'hDEADBEEF);
        // two wait states: ID register
        xfer(1, 0, 5'd0, 32'd0, rd, rr, re);
        chk("w2_id_data", 1, rd, ID);
        chk("w2_id_err", 1, 32'(re), 32'd0);
        // error accesses
        xfer(0, 1, 5'd0, 32'h1234_5678, rd, rr, re);
        chk("wr0_err", 0, 32'(re), 32'd1);
        xfer(0, 0, 5'd20, 32'd0, rd, rr, re);
        chk("rd20_err", 0, 32'(re), 32'd1);
        chk("rd20_data", 0, rd, 32'd0);
        xfer(0, 0, 5'd0, 32'd0, rd, rr, re);
        chk("reg0_kept", 0, rd, ID);
        idle(1);
        @(negedge clk);
        chk("errc_two", 0, 32'(errc[0]), 32'd2);
        // protocol error and abort
        proto(1);
        abort(1, 1);
        idle(1);
        @(negedge clk);
        chk("errc_proto", 1, 32'(errc[1]), 32'd1);
        // reset in the middle of a wait
        xfer(2, 1, 5'd0, 32'd1, rd, rr, re);
        xfer(2, 1, 5'd5, 32'h0000_1234, rd, rr, re);
        step(2, 0, 1, 0, 1, 5'd5, 32'hFFFF_FFFF, 0, 0, 32'd0);
        step(2, 0, 1, 1, 1, 5'd5, 32'hFFFF_FFFF, 0, 0, 32'd0);
        step(2, 1, 1, 1, 1, 5'd5, 32'hFFFF_FFFF, 0, 0, 32'd0);
        idle(1);
        @(negedge clk);
        chk("rst_errc", 2, 32'(errc[2]), 32'd0);
        xfer(2, 0, 5'd5, 32'd0, rd, rr, re);
        chk("rst_reg5", 2, rd, 32'd0);
        // back-to-back writes then reads
        for (int a = 1; a < 16; a++) begin
            wd[a] = $urandom;
            xfer(1, 1, 5'(a), wd[a], rd, rr, re);
        end
        for (int a = 1; a < 16; a++) begin
            xfer(1, 0, 5'(a), 32'd0, rd, rr, re);
            chk("b2b_data", 1, rd, wd[a]);
        end
        // error counter saturation
        for (int i = 0; i < 260; i++) xfer(0, i[0], i[0] ? 5'd0 : 5'd31, $urandom, rd, rr, re);
        idle(1);
        @(negedge clk);
        chk("errc_sat", 0, 32'(errc[0]), 32'hFF);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            int k, op;
            k = $urandom_range(0, 2);
            op = $urandom_range(0, 9);
            if (op <= 5)
                xfer(k, 1'($urandom), $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 15)), $urandom, rd, rr, re);
            else if (op == 6)
                proto(k);
            else if (op == 7 && wcf(k) > 0)
                abort(k, $urandom_range(0, wcf(k) - 1));
            else
                idle($urandom_range(1, 3));
        end
        idle(2);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
